// File: rtl/ca_pkg.sv
// Shared types and width defaults for the instruction-cache storage array.
package ca_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [DATA_W-1:0] data;
    } ca_entry_t;

endpackage

// File: rtl/ca_prio_enc.sv
// Lowest-index-set-bit encoder: returns the index of the first set request bit and
// whether any bit was set at all.
module ca_prio_enc #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scanning downwards lets the lowest set bit win the last assignment.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ca_store.sv
// Fully associative instruction-cache storage: combinational PC lookup plus fill/clear writes.
// Optional hit/fill performance counters are enabled with `define CA_STORE_PERF_EN.
module ca_store
    import ca_pkg::*;
#(
    parameter int CACHE_ENTRIES   = 8,
    parameter int CACHE_ADDR_LEFT = $clog2(CACHE_ENTRIES) - 1,
    parameter int ADDR_W          = ca_pkg::ADDR_W,
    parameter int DATA_W          = ca_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [ADDR_W-1:0]          pc,
    input  logic                       cache_read,
    input  logic                       cache_write_,
    input  logic [CACHE_ADDR_LEFT:0]   cache_w_addr,
    input  logic                       new_valid,
    input  logic [DATA_W-1:0]          mem_instr,
    output logic                       cache_hit,
    output logic                       cache_full,
    output logic [DATA_W-1:0]          instr_out,
    output logic [CACHE_ADDR_LEFT+1:0] valid_count
`ifdef CA_STORE_PERF_EN
    ,
    output logic [31:0]                hit_cnt,
    output logic [31:0]                fill_cnt
`endif
);

    localparam int IW = CACHE_ADDR_LEFT + 1;
    localparam int CW = CACHE_ADDR_LEFT + 2;

    logic [CACHE_ENTRIES-1:0] valid_reg;
    logic [ADDR_W-1:0]        tag_reg  [CACHE_ENTRIES];
    logic [DATA_W-1:0]        data_reg [CACHE_ENTRIES];
    logic [CW-1:0]            valid_count_reg;

    logic [CACHE_ENTRIES-1:0] match;
    logic [CACHE_ENTRIES-1:0] invalid;
    logic [IW-1:0]            match_idx;
    logic [IW-1:0]            free_idx;
    logic                     match_found;
    logic                     free_found;

    logic                     fill_en;
    logic                     fill_new;
    logic [IW-1:0]            fill_idx;
    logic                     clr_en;

    generate
        for (genvar gi = 0; gi < CACHE_ENTRIES; gi++) begin : g_cmp
            assign match[gi]   = valid_reg[gi] && (tag_reg[gi] == pc);
            assign invalid[gi] = ~valid_reg[gi];
        end
    endgenerate

    ca_prio_enc #(.N(CACHE_ENTRIES), .IW(IW)) u_match_enc (
        .req   (match),
        .idx   (match_idx),
        .found (match_found)
    );

    ca_prio_enc #(.N(CACHE_ENTRIES), .IW(IW)) u_free_enc (
        .req   (invalid),
        .idx   (free_idx),
        .found (free_found)
    );

    assign cache_hit   = cache_read && match_found;
    assign instr_out   = cache_hit ? data_reg[match_idx] : '0;
    assign cache_full  = &valid_reg;
    assign valid_count = valid_count_reg;

    // An existing match is refreshed in place so the array never holds duplicate tags.
    assign fill_en  = !cache_write_ && new_valid && (match_found || free_found);
    assign fill_new = fill_en && !match_found;
    assign fill_idx = match_found ? match_idx : free_idx;
    assign clr_en   = !cache_write_ && !new_valid && valid_reg[cache_w_addr];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            valid_reg       <= '0;
            valid_count_reg <= '0;
            for (int i = 0; i < CACHE_ENTRIES; i++) begin
                tag_reg[i]  <= '0;
                data_reg[i] <= '0;
            end
        end else begin
            if (fill_en) begin
                valid_reg[fill_idx] <= 1'b1;
                tag_reg[fill_idx]   <= pc;
                data_reg[fill_idx]  <= mem_instr;
            end
            if (clr_en) begin
                valid_reg[cache_w_addr] <= 1'b0;
            end
            if (fill_new) begin
                valid_count_reg <= valid_count_reg + CW'(1);
            end else if (clr_en) begin
                valid_count_reg <= valid_count_reg - CW'(1);
            end
        end
    end

`ifdef CA_STORE_PERF_EN
    logic [31:0] hit_cnt_reg;
    logic [31:0] fill_cnt_reg;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            hit_cnt_reg  <= '0;
            fill_cnt_reg <= '0;
        end else begin
            if (cache_hit) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
            if (fill_en) begin
                fill_cnt_reg <= fill_cnt_reg + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign fill_cnt = fill_cnt_reg;
`endif

endmodule

// File: doc/ca_store.md
# ca_store

Fully associative instruction-cache storage array sitting directly beside the fetch-stage cache controller. It performs the tag lookup on the current fetch PC and reports `cache_hit`/`cache_full`. It executes the controller's fill and clear writes using the instruction word returned from instruction memory. It also supplies the cached instruction to the fetch/decode pipeline register.

## Interface
Parameters:
- `CACHE_ENTRIES`, 8, number of entries; power of two, ≥2
- `CACHE_ADDR_LEFT`, `$clog2(CACHE_ENTRIES)-1`, MSB of entry index
- `ADDR_W`, 32, fetch PC / tag width
- `DATA_W`, 32, instruction word width

Ports:
- `clk`  in  1  system clock
- `rst_`  in  1  reset, asynchronous, active-low
- `pc`  in  ADDR_W  fetch address; full PC is the tag
- `cache_read`  in  1  lookup enable from controller
- `cache_write_`  in  1  active-low write strobe from controller
- `cache_w_addr`  in  CACHE_ADDR_LEFT+1  entry index for clear operations
- `new_valid`  in  1  1 = fill, 0 = clear entry at `cache_w_addr`
- `mem_instr`  in  DATA_W  instruction word from instruction memory for current `pc`
- `cache_hit`  out  1  lookup hit
- `cache_full`  out  1  all entries valid
- `instr_out`  out  DATA_W  instruction of hitting entry
- `valid_count`  out  CACHE_ADDR_LEFT+2  number of valid entries

## Operation
- Per-entry state: `valid` bit, `tag[ADDR_W]`, `data[DATA_W]`, all registers.
- Lookup is combinational: `match[i] = valid[i] && tag[i]==pc`.
  - `cache_hit = cache_read && |match`.
  - `instr_out` = `data` of the lowest-index matching entry when `cache_hit`, else all zeros.
- Write is sampled at posedge when `cache_write_==0`.
- Fill (`new_valid=1`), target selected as follows:
  - If some entry already matches `pc`, overwrite that entry (no duplicates).
  - Otherwise use the lowest-index invalid entry.
  - `cache_w_addr` is ignored.
  - Target gets `valid=1`, `tag=pc`, `data=mem_instr`.
  - If no match and no invalid entry, the write is dropped and state is unchanged.
- Clear (`new_valid=0`): `valid[cache_w_addr]<=0`. Tag and data are untouched. Clearing an already-invalid entry is a no-op.
- `cache_full = &valid`.
- `valid_count` is a register kept equal to the popcount of `valid`: +1 on a fill into an invalid entry, −1 on a clear of a valid entry, unchanged otherwise.
- Lookup and write in the same cycle: lookup reflects pre-write state. The new entry is visible from the next cycle.

## Timing
- Reset (async assert, sync release): all `valid`=0, tags/data=0, `valid_count`=0.
  - Outputs after reset: `cache_hit`=0, `cache_full`=0, `instr_out`=0.
- Hit latency 0 cycles (combinational from `pc`/`cache_read`).
- Fill-to-hit latency 1 cycle: fill at edge N, hit visible after edge N.
- Clear-to-miss latency 1 cycle.
- `cache_full` and `valid_count` update one cycle after the causing write edge.
- Reset mid-fill: the write is lost and the array is empty.

## Configuration
- `CA_STORE_PERF_EN` defined: adds outputs `hit_cnt[31:0]` and `fill_cnt[31:0]`, reset to 0.
  - `hit_cnt` increments each cycle `cache_hit`=1.
  - `fill_cnt` increments on each accepted fill, including overwrite fills, but not dropped fills.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; there is no other behavioural difference.

## Structure
- Shared package `ca_pkg`: `ADDR_W`/`DATA_W` defaults, `ca_entry_t` struct (`valid`, `tag`, `data`).
- Sub-module `ca_prio_enc`: parameterised lowest-index-set-bit encoder returning index plus `found`.
  - Instantiated twice: once for the match vector, once for the invalid vector.

## Test plan
- Reset, then `pc=0x100`, `cache_read=1`: expect `cache_hit=0`, `instr_out=0`, `valid_count=0`.
- Fill `pc=0x100`, `mem_instr=0x2008_0005`; next cycle lookup 0x100: expect hit, `instr_out=0x20080005`, `valid_count=1`.
- Fill 8 distinct PCs 0x0..0x1C: expect `cache_full=1` after the 8th edge. A 9th fill of PC 0x40 is dropped: 0x40 misses, `valid_count=8`.
- With the cache full, clear `cache_w_addr=3`: expect `cache_full=0`, PC 0xC misses. The next fill of 0x40 lands in entry 3 and hits.
- Refill existing `pc=0x4` with `mem_instr=0xDEAD_BEEF`: expect `valid_count` unchanged and a hit returning 0xDEADBEEF. With `CA_STORE_PERF_EN`, expect `fill_cnt` to increment.
- Assert `rst_` low mid-fill with a populated array: all outputs go to 0 immediately, and prior PCs miss after release.
